time_display_driver: RTL

Downstream display stage of the digital clock. Consumes the six packed BCD digit counts (seconds, minutes, 12-hour hours) produced by the six digit counters and drives two outputs: six direct seven-segment displays and a time-multiplexed single-segment/anode bus. It blinks the digit being edited in set mode and blanks the hour-tens digit when it is zero.

---
 rtl/clock_pkg.sv | 36 +++
 rtl/seg7_decode.sv | 28 ++
 rtl/time_display_driver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared encodings for the digital clock: mode values, digit indices and
// active-low seven-segment patterns (bit order g..a).
package clock_pkg;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_SET   = 4'd1,
        S_START = 4'd3
    } clk_state_e;

    typedef enum logic [2:0] {
        LSB = 3'd0,
        HSB = 3'd1,
        LMB = 3'd2,
        HMB = 3'd3,
        LHB = 3'd4,
        HHB = 3'd5
    } digit_e;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal codes
// show a dash so corrupted counter values are visible rather than misleading.
module seg7_decode
    import clock_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/time_display_driver.sv
// Display stage of the digital clock: six direct 7-seg outputs plus a scanned
// seg/an bus, hour-tens blanking and set-mode blink (blink only when DISPLAY_BLINK_EN).
module time_display_driver
    import clock_pkg::*;
#(
    parameter int BLINK_HALF = 12500000,
    parameter int SCAN_DIV   = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  state,
    input  logic [23:0] currentBits,
    input  logic [2:0]  editDigit,
    output logic [41:0] hexAll,
    output logic [6:0]  seg,
    output logic [5:0]  an
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic clear;
    logic in_set;
    assign clear  = reset || (state == S_RESET);
    assign in_set = !clear && (state == S_SET);

    logic [NUM_DIGITS-1:0][6:0] raw_pat;
    logic [NUM_DIGITS-1:0][6:0] final_pat;
    logic [NUM_DIGITS-1:0]      blank_sel;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .bcd_i (currentBits[g*4 +: 4]),
            .seg_o (raw_pat[g])
        );
    end

`ifdef DISPLAY_BLINK_EN
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               hidden_q, hidden_d;
    logic [2:0]         edit_prev_q;
    logic               edit_chg;
    logic               blank_now;

    // A fresh selection is shown at once, even if the old phase was hidden.
    assign edit_chg  = (editDigit != edit_prev_q);
    assign blank_now = in_set && hidden_q && !edit_chg;

    always_comb begin
        blink_cnt_d = '0;
        hidden_d    = 1'b0;
        if (in_set && !edit_chg) begin
            if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
                hidden_d = ~hidden_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                hidden_d    = hidden_q;
            end
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            blank_sel[i] = blank_now && (editDigit == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        edit_prev_q <= editDigit;
        if (clear) begin
            blink_cnt_q <= '0;
            hidden_q    <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            hidden_q    <= hidden_d;
        end
    end
`else
    logic unused_edit;
    assign unused_edit = ^editDigit;
    assign blank_sel   = '0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            final_pat[i] = blank_sel[i] ? SEG_BLANK : raw_pat[i];
        end
        if (currentBits[23:20] == 4'd0) begin
            final_pat[HHB] = SEG_BLANK;
        end
    end

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        scan_idx_q, scan_idx_d;
    logic [6:0]        seg_sel;
    logic [41:0]       hex_all_q;
    logic [6:0]        seg_q;
    logic [5:0]        an_q;

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == HHB) ? 3'd0 : scan_idx_q + 3'd1;
        end
        // Select from post-processed patterns so seg always matches hexAll.
        seg_sel = SEG_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == 3'(i)) seg_sel = final_pat[i];
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            scan_cnt_q <= '0;
            scan_idx_q <= 3'd0;
            hex_all_q  <= '1;
            seg_q      <= SEG_BLANK;
            an_q       <= 6'h3F;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            hex_all_q  <= final_pat;
            seg_q      <= seg_sel;
            an_q       <= ~(6'd1 << scan_idx_q);
        end
    end

    assign hexAll = hex_all_q;
    assign seg    = seg_q;
    assign an     = an_q;

endmodule
